// File: rtl/rhythm_judge_pkg.sv
// Shared types and default tuning constants for the rhythm judgement core.
package rhythm_judge_pkg;

    typedef enum logic [1:0] {
        GRADE_MISS    = 2'd0,
        GRADE_GOOD    = 2'd1,
        GRADE_PERFECT = 2'd2
    } grade_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_JUDGE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int DEF_PERFECT_WIN = 2;
    localparam int DEF_GOOD_WIN    = 6;
    localparam int DEF_PERFECT_PTS = 3;
    localparam int DEF_GOOD_PTS    = 1;
    localparam int DEF_BONUS_SHIFT = 2;

endpackage

// File: rtl/rhythm_judge_window.sv
// Combinational grading of one cycle: decides whether the pending note is graded now and how.
module judge_window
    import rhythm_judge_pkg::*;
#(
    parameter int CLOCK_BITS  = 16,
    parameter int PERFECT_WIN = DEF_PERFECT_WIN,
    parameter int GOOD_WIN    = DEF_GOOD_WIN
) (
    input  logic signed [CLOCK_BITS-1:0] diff,
    input  logic                         goal_hit,
    input  logic                         other_hit,
    output grade_t                       grade,
    output logic                         fire
);

    localparam logic signed [CLOCK_BITS-1:0] PW = CLOCK_BITS'(PERFECT_WIN);
    localparam logic signed [CLOCK_BITS-1:0] GW = CLOCK_BITS'(GOOD_WIN);

    logic in_perfect;
    logic in_good;
    logic late;

    // Range compares avoid taking |diff|, which overflows at the most negative value.
    assign in_perfect = (diff >= -PW) && (diff <= PW);
    assign in_good    = (diff >= -GW) && (diff <= GW);
    assign late       = (diff > GW);

    always_comb begin
        grade = GRADE_MISS;
        fire  = 1'b0;
        if (goal_hit && in_good) begin
            fire  = 1'b1;
            grade = in_perfect ? GRADE_PERFECT : GRADE_GOOD;
        end else if (late) begin
            fire = 1'b1;
        end else if (!goal_hit && other_hit && in_good) begin
            fire = 1'b1;
        end
    end

endmodule

// File: rtl/rhythm_judge.sv
// Multi-lane play-mode judge: fetches notes, grades player hits, keeps combo and saturating score.
module rhythm_judge
    import rhythm_judge_pkg::*;
#(
    parameter int LANES       = 7,
    parameter int CLOCK_BITS  = 16,
    parameter int PERFECT_WIN = DEF_PERFECT_WIN,
    parameter int GOOD_WIN    = DEF_GOOD_WIN,
    parameter int PERFECT_PTS = DEF_PERFECT_PTS,
    parameter int GOOD_PTS    = DEF_GOOD_PTS,
    parameter int BONUS_SHIFT = DEF_BONUS_SHIFT,
    parameter int COMBO_BITS  = 10,
    parameter int SCORE_BITS  = 21,
    localparam int LANE_BITS  = $clog2(LANES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [CLOCK_BITS-1:0] sys_time,
    input  logic                  goal_valid,
    output logic                  goal_ready,
    input  logic [LANE_BITS-1:0]  goal_lane,
    input  logic [CLOCK_BITS-1:0] goal_time,
    input  logic                  goal_last,
    input  logic [LANES-1:0]      hit,
    output logic [LANES-1:0]      lane_led,
    output logic                  judge_valid,
    output logic [1:0]            judge_grade,
    output logic [COMBO_BITS-1:0] combo,
    output logic [COMBO_BITS-1:0] max_combo,
    output logic [SCORE_BITS-1:0] score,
    output logic                  done
);

    localparam int SUM_W = SCORE_BITS + 2;
    localparam logic [SCORE_BITS-1:0] SCORE_MAX = '1;
    localparam logic [COMBO_BITS-1:0] COMBO_MAX = '1;

    state_t                  state;
    logic [LANE_BITS-1:0]    lane_q;
    logic [CLOCK_BITS-1:0]   time_q;
    logic                    last_q;
    logic [LANES-1:0]        goal_mask;
    logic signed [CLOCK_BITS-1:0] diff;
    logic                    goal_hit;
    logic                    other_hit;
    grade_t                  win_grade;
    logic                    win_fire;
    logic [COMBO_BITS-1:0]   next_combo;
    logic [SCORE_BITS-1:0]   next_score;

    function automatic logic [SCORE_BITS-1:0] sat_score(input logic [SCORE_BITS-1:0] s,
                                                         input logic [COMBO_BITS-1:0] c,
                                                         input grade_t g);
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] pts;
        pts = (g == GRADE_PERFECT) ? SUM_W'(PERFECT_PTS) : SUM_W'(GOOD_PTS);
        sum = {2'b00, s} + pts + SUM_W'(c >> BONUS_SHIFT);
        return (sum > {2'b00, SCORE_MAX}) ? SCORE_MAX : sum[SCORE_BITS-1:0];
    endfunction

    function automatic logic [COMBO_BITS-1:0] sat_combo_inc(input logic [COMBO_BITS-1:0] c);
        return (c == COMBO_MAX) ? c : c + COMBO_BITS'(1);
    endfunction

    // Wrap-transparent signed distance from the target; hits only count while waiting.
    assign goal_mask = LANES'(1) << lane_q;
    assign diff      = signed'(sys_time - time_q);
    assign goal_hit  = (state == S_WAIT) && |(hit & goal_mask);
    assign other_hit = (state == S_WAIT) && |(hit & ~goal_mask);

    judge_window #(
        .CLOCK_BITS (CLOCK_BITS),
        .PERFECT_WIN(PERFECT_WIN),
        .GOOD_WIN   (GOOD_WIN)
    ) u_window (
        .diff     (diff),
        .goal_hit (goal_hit),
        .other_hit(other_hit),
        .grade    (win_grade),
        .fire     (win_fire)
    );

    always_comb begin
        next_combo = (win_grade == GRADE_MISS) ? '0 : sat_combo_inc(combo);
        next_score = (win_grade == GRADE_MISS) ? score : sat_score(score, combo, win_grade);
    end

    // Note payload only needs to be valid in the accept cycle.
    always_ff @(posedge clk) begin
        if (en && state == S_FETCH && goal_valid) begin
            lane_q <= goal_lane;
            time_q <= goal_time;
            last_q <= goal_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            goal_ready  <= 1'b0;
            lane_led    <= '0;
            judge_valid <= 1'b0;
            judge_grade <= '0;
            combo       <= '0;
            max_combo   <= '0;
            score       <= '0;
            done        <= 1'b0;
        end else if (!en) begin
            state       <= S_IDLE;
            goal_ready  <= 1'b0;
            lane_led    <= '0;
            judge_valid <= 1'b0;
            judge_grade <= '0;
            combo       <= '0;
            max_combo   <= '0;
            score       <= '0;
            done        <= 1'b0;
        end else begin
            judge_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    state      <= S_FETCH;
                    goal_ready <= 1'b1;
                end
                S_FETCH: begin
                    if (goal_valid) begin
                        state      <= S_WAIT;
                        goal_ready <= 1'b0;
                        lane_led   <= LANES'(1) << goal_lane;
                    end
                end
                S_WAIT: begin
                    if (win_fire) begin
                        state       <= S_JUDGE;
                        judge_valid <= 1'b1;
                        judge_grade <= win_grade;
                        combo       <= next_combo;
                        score       <= next_score;
                        if (next_combo > max_combo) max_combo <= next_combo;
                    end
                end
                S_JUDGE: begin
                    lane_led <= '0;
                    if (last_q) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state      <= S_FETCH;
                        goal_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rhythm_judge.sv
// Randomised scoreboard bench for rhythm_judge with a rule-level reference model.
module tb_rhythm_judge;

    localparam int GW    = 6;
    localparam int PW    = 2;
    localparam int SMAX  = (1 << 21) - 1;
    localparam int CMAX  = (1 << 10) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [15:0] sys_time = '0;
    logic        goal_valid = 1'b0;
    logic        goal_ready;
    logic [2:0]  goal_lane = '0;
    logic [15:0] goal_time = '0;
    logic        goal_last = 1'b0;
    logic [6:0]  hit = '0;
    logic [6:0]  lane_led;
    logic        judge_valid;
    logic [1:0]  judge_grade;
    logic [9:0]  combo;
    logic [9:0]  max_combo;
    logic [20:0] score;
    logic        done;

    rhythm_judge dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sys_time   (sys_time),
        .goal_valid (goal_valid),
        .goal_ready (goal_ready),
        .goal_lane  (goal_lane),
        .goal_time  (goal_time),
        .goal_last  (goal_last),
        .hit        (hit),
        .lane_led   (lane_led),
        .judge_valid(judge_valid),
        .judge_grade(judge_grade),
        .combo      (combo),
        .max_combo  (max_combo),
        .score      (score),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        int grade;
        int combo;
        int maxc;
        int score;
        int at;
    } exp_t;

    exp_t sbq[$];

    int m_combo = 0;
    int m_max = 0;
    int m_score = 0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {goal_ready, lane_led, judge_valid, judge_grade, combo, max_combo, score, done}, 0);
    endtask

    // Grading rules expressed on the integer tick distance; -1 means nothing happens this cycle.
    function automatic int model_grade(input int d, input bit g, input bit o);
        int ad;
        ad = (d < 0) ? -d : d;
        if (g && ad <= GW) return (ad <= PW) ? 2 : 1;
        if (d > GW) return 0;
        if (!g && o && ad <= GW) return 0;
        return -1;
    endfunction

    task automatic model_apply(input int g);
        int pts;
        if (g == 0) begin
            m_combo = 0;
        end else begin
            pts = (g == 2) ? 3 : 1;
            m_score = m_score + pts + (m_combo / 4);
            if (m_score > SMAX) m_score = SMAX;
            m_combo = (m_combo >= CMAX) ? CMAX : m_combo + 1;
        end
        if (m_combo > m_max) m_max = m_combo;
    endtask

    task automatic model_clear();
        m_combo = 0;
        m_max = 0;
        m_score = 0;
    endtask

    // kind: 0 goal-lane hit, 1 wrong-lane hit, 2 no hit, 3 goal and wrong lane together (at d == plan_d)
    task automatic issue_note(input int lane, input logic [15:0] gt, input bit last,
                              input int start_d, input int kind, input int plan_d);
        int waited;
        int d;
        int g;
        bit graded;
        logic signed [15:0] ds;
        logic [6:0] mask;
        waited = 0;
        goal_valid = 1'b1;
        goal_lane = 3'(lane);
        goal_time = gt;
        goal_last = last;
        while (!goal_ready && waited < 20) begin
            @(negedge clk);
            sys_time++;
            waited++;
        end
        check("goal_ready_fetch", goal_ready, 1);
        sys_time = gt + 16'(start_d - 1);
        @(negedge clk);
        sys_time++;
        goal_valid = 1'b0;
        goal_lane = 3'($urandom);
        goal_time = 16'($urandom);
        goal_last = 1'($urandom);
        check("lane_led_wait", lane_led, 7'(1) << lane);
        mask = 7'(1) << lane;
        graded = 0;
        for (int k = 0; k < 40 && !graded; k++) begin
            ds = sys_time - gt;
            d = int'(ds);
            hit = '0;
            if (d == plan_d) begin
                if (kind == 0 || kind == 3) hit[lane] = 1'b1;
                if (kind == 1 || kind == 3) hit[(lane + 1 + $urandom_range(0, 5)) % 7] = 1'b1;
            end
            g = model_grade(d, hit[lane], |(hit & ~mask));
            if (g >= 0) begin
                model_apply(g);
                sbq.push_back('{g, m_combo, m_max, m_score, cyc + 1});
                graded = 1;
            end
            @(negedge clk);
            sys_time++;
            hit = '0;
        end
        check("lane_led_judge", lane_led, mask);
        @(negedge clk);
        sys_time++;
        check("lane_led_after", lane_led, 0);
        if (last) begin
            check("done_after_last", done, 1);
            check("ready_after_last", goal_ready, 0);
        end else begin
            check("ready_reassert", goal_ready, 1);
        end
    endtask

    // Monitor: every judge pulse must match the oldest expectation, in the expected cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (judge_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_judge", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("judge_cycle", cyc, e.at);
                    check("judge_grade", judge_grade, e.grade);
                    check("combo", combo, e.combo);
                    check("max_combo", max_combo, e.maxc);
                    check("score", score, e.score);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        en = 1'b1;
        @(negedge clk);
        check("ready_after_en", goal_ready, 1);

        // First note: lane 3 at t=100, perfect at t=101 from combo 0.
        issue_note(3, 16'd100, 0, -2, 0, 1);
        check("first_score", score, 3);
        check("first_combo", combo, 1);
        for (int i = 0; i < 4; i++) issue_note(i, 16'(200 + 50 * i), 0, -1, 0, 0);
        check("five_perfect_score", score, 16);
        check("five_perfect_combo", combo, 5);

        // Timeout, exact good edge, early ignore, wrap-around good and wrong-lane miss.
        issue_note(1, 16'd1000, 0, -3, 2, 0);
        check("timeout_combo", combo, 0);
        check("timeout_max_kept", max_combo, 5);
        issue_note(0, 16'd500, 0, -2, 0, GW);
        check("edge_good_grade", judge_grade, 1);
        issue_note(6, 16'd700, 0, -10, 0, -8);
        issue_note(2, 16'hFFFE, 0, -5, 0, 3);
        check("wrap_good_grade", judge_grade, 1);
        issue_note(4, 16'hFFFE, 0, -8, 1, -4);
        check("wrong_lane_miss", judge_grade, 0);
        issue_note(5, 16'd3000, 0, -4, 3, -1);

        for (int i = 0; i < 150; i++) begin
            issue_note($urandom_range(0, 6), 16'($urandom), 0, -int'($urandom_range(0, 12)),
                       $urandom_range(0, 3), int'($urandom_range(0, 16)) - 10);
        end

        issue_note(2, 16'd4000, 1, -1, 0, 0);
        @(negedge clk);
        check("done_holds", done, 1);
        check("score_holds", score, m_score);
        en = 1'b0;
        @(negedge clk);
        check_all_zero("en_drop_outputs");
        model_clear();
        en = 1'b1;

        // Dropping en while a note waits discards it.
        goal_valid = 1'b1;
        goal_lane = 3'd5;
        goal_time = sys_time + 16'd1000;
        goal_last = 1'b0;
        n = 0;
        while (!goal_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        goal_valid = 1'b0;
        check("drop_wait_led", lane_led, 7'b0100000);
        en = 1'b0;
        @(negedge clk);
        check_all_zero("drop_mid_note");
        en = 1'b1;

        // Long perfect run to drive both counters into saturation.
        n = 0;
        while (m_score < SMAX && n < 12000) begin
            issue_note($urandom_range(0, 6), 16'($urandom), 0, 0, 0, 0);
            n++;
        end
        issue_note(1, 16'd77, 0, 0, 0, 0);
        check("score_saturated", score, SMAX);
        check("combo_saturated", combo, CMAX);
        check("max_combo_saturated", max_combo, CMAX);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
